// File: rtl/fir_scie_sequencer.sv
// rtl/fir_scie_sequencer.sv - LOAD/PUSH/READ instruction sequencer for the pipelined FIR unit
// Optional FIR_SEQ_PERF_EN adds perf_samples / perf_stall counters.
`timescale 1ns/1ps
module fir_scie_sequencer #(
  parameter int          NUM_TAPS = 5,
  parameter int          DATA_W   = 64,
  parameter logic [31:0] OP_LOAD  = 32'h0000000B,
  parameter logic [31:0] OP_PUSH  = 32'h0000002B,
  parameter logic [31:0] OP_READ  = 32'h0000005B,
  parameter int          PUSH_GAP = 1,
  parameter int          READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_index,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              dp_valid,
  output logic [31:0]       dp_insn,
  output logic [DATA_W-1:0] dp_rs1,
  output logic [31:0]       dp_rs2,
  input  logic [DATA_W-1:0] dp_rd,
  output logic              busy,
  output logic              cfg_err
`ifdef FIR_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_samples,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PUSH, S_GAP, S_READ, S_WAITRD, S_HOLD
  } state_t;

  localparam logic [8:0] NUM_TAPS_W = 9'(NUM_TAPS);
  localparam logic [3:0] GAP_INIT   = 4'(PUSH_GAP - 1);
  localparam logic [3:0] LAT_INIT   = 4'(READ_LAT - 1);

  state_t     state;
  logic       idle_rdy;
  logic [3:0] cnt;
  logic       cfg_fire;
  logic       in_fire;

  // Ready is registered so both readies read 0 while reset is held.
  assign cfg_ready = idle_rdy;
  assign in_ready  = idle_rdy & ~cfg_valid;
  assign cfg_fire  = cfg_valid & idle_rdy;
  assign in_fire   = in_valid & in_ready;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idle_rdy  <= 1'b0;
      cnt       <= '0;
      dp_valid  <= 1'b0;
      dp_insn   <= '0;
      dp_rs1    <= '0;
      dp_rs2    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      dp_valid <= 1'b0;
      dp_insn  <= '0;
      dp_rs1   <= '0;
      dp_rs2   <= '0;
      case (state)
        S_IDLE: begin
          idle_rdy <= 1'b1;
          if (cfg_fire) begin
            if ({1'b0, cfg_index} < NUM_TAPS_W) begin
              state    <= S_LOAD;
              idle_rdy <= 1'b0;
              dp_valid <= 1'b1;
              dp_insn  <= OP_LOAD;
              dp_rs1   <= cfg_data;
              dp_rs2   <= {24'd0, cfg_index};
            end else begin
              cfg_err <= 1'b1;
            end
          end else if (in_fire) begin
            state    <= S_PUSH;
            idle_rdy <= 1'b0;
            dp_valid <= 1'b1;
            dp_insn  <= OP_PUSH;
            dp_rs1   <= in_data;
          end
        end
        S_LOAD: begin
          state    <= S_IDLE;
          idle_rdy <= 1'b1;
        end
        S_PUSH: begin
          if (PUSH_GAP == 0) begin
            state    <= S_READ;
            dp_valid <= 1'b1;
            dp_insn  <= OP_READ;
          end else begin
            state <= S_GAP;
            cnt   <= GAP_INIT;
          end
        end
        S_GAP: begin
          if (cnt == 4'd0) begin
            state    <= S_READ;
            dp_valid <= 1'b1;
            dp_insn  <= OP_READ;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_READ: begin
          state <= S_WAITRD;
          cnt   <= LAT_INIT;
        end
        S_WAITRD: begin
          // dp_rd is only valid in the last wait cycle.
          if (cnt == 4'd0) begin
            state     <= S_HOLD;
            out_data  <= dp_rd;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            idle_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          idle_rdy <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIR_SEQ_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_samples <= '0;
      perf_stall   <= '0;
    end else if (state == S_HOLD) begin
      if (out_ready) perf_samples <= perf_samples + 32'd1;
      else           perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_scie_sequencer.sv
// tb/tb_fir_scie_sequencer.sv - scoreboard bench for fir_scie_sequencer with a behavioural FIR unit
`timescale 1ns/1ps
module tb_fir_scie_sequencer;
  localparam int          NUM_TAPS = 5;
  localparam int          DATA_W   = 64;
  localparam logic [31:0] OP_LOAD  = 32'h0000000B;
  localparam logic [31:0] OP_PUSH  = 32'h0000002B;
  localparam logic [31:0] OP_READ  = 32'h0000005B;
  localparam int          PUSH_GAP = 1;
  localparam int          READ_LAT = 1;
  localparam int          BOUND    = 300;

  logic              clock, reset_n;
  logic              cfg_valid, cfg_ready;
  logic [7:0]        cfg_index;
  logic [DATA_W-1:0] cfg_data;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              dp_valid;
  logic [31:0]       dp_insn;
  logic [DATA_W-1:0] dp_rs1;
  logic [31:0]       dp_rs2;
  logic [DATA_W-1:0] dp_rd;
  logic              busy, cfg_err;

  fir_scie_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dp_valid(dp_valid), .dp_insn(dp_insn), .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rd(dp_rd),
    .busy(busy), .cfg_err(cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference model: coefficient table and sample history, newest sample at index 0
  logic [63:0] coef_m [NUM_TAPS];
  logic [63:0] hist_m [NUM_TAPS];
  logic [63:0] exp_q [$];
  bit          err_m;

  // FIR unit stand-in, driven only by the instruction bus
  logic [63:0] coef_u [NUM_TAPS];
  logic [63:0] hist_u [NUM_TAPS];
  logic [63:0] rd_val;
  bit          read_seen;
  int          wcnt;

  initial begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      coef_m[i] = '0; hist_m[i] = '0; coef_u[i] = '0; hist_u[i] = '0;
    end
    err_m = 0; read_seen = 0; wcnt = 0; rd_val = '0;
  end

  always @(negedge clock) begin
    if (reset_n && dp_valid) begin
      if (dp_insn == OP_LOAD && dp_rs2 < NUM_TAPS) coef_u[dp_rs2] = dp_rs1;
      else if (dp_insn == OP_PUSH) begin
        for (int i = NUM_TAPS - 1; i > 0; i--) hist_u[i] = hist_u[i-1];
        hist_u[0] = dp_rs1;
      end else if (dp_insn == OP_READ) begin
        rd_val = '0;
        for (int i = 0; i < NUM_TAPS; i++) rd_val = rd_val + coef_u[i] * hist_u[i];
        read_seen = 1;
      end
    end
  end

  // dp_rd carries the result only in the cycle READ_LAT after READ; noise otherwise
  initial begin
    dp_rd = '0;
    forever begin
      @(posedge clock); #1;
      if (read_seen) begin wcnt = READ_LAT; read_seen = 0; end
      else if (wcnt > 0) wcnt--;
      dp_rd = (wcnt == 1) ? rd_val : {$urandom, $urandom};
    end
  end

  // out_ready: 0 = hold low, 1 = high, 2 = random
  int or_mode = 1;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock); #2;
      out_ready = (or_mode == 2) ? ($urandom_range(0, 2) != 0) : (or_mode == 1);
    end
  end

  // Monitor and scoreboard
  int          cyc = 0, push_cyc = 0, read_cyc = 0;
  bit          prev_ov = 0, prev_or = 0;
  logic [63:0] prev_od = '0;
  logic [63:0] exp_v, y;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      err_m = 0; prev_ov = 0; prev_or = 0;
    end else begin
      chk(cfg_err == err_m, "cfg_err", cfg_err, err_m);
      if (!dp_valid)
        chk({dp_insn, dp_rs1, dp_rs2} == '0, "dp_idle_zero", dp_rs1, 0);
      else if (dp_insn == OP_PUSH) push_cyc = cyc;
      else if (dp_insn == OP_READ) begin
        chk(cyc - push_cyc == PUSH_GAP + 1, "push_read_gap", cyc - push_cyc, PUSH_GAP + 1);
        chk({dp_rs1, dp_rs2} == '0, "read_operands", dp_rs1, 0);
        read_cyc = cyc;
      end else if (dp_insn != OP_LOAD)
        chk(0, "dp_insn_legal", dp_insn, OP_LOAD);
      if (out_valid && !prev_ov)
        chk(cyc - read_cyc == READ_LAT + 1, "read_to_out", cyc - read_cyc, READ_LAT + 1);
      if (prev_ov && !prev_or)
        chk(out_valid && out_data == prev_od, "out_hold", out_data, prev_od);
      if (out_valid)
        chk(!in_ready && !dp_valid, "stall_while_hold", {in_ready, dp_valid}, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(0, "unexpected_out", out_data, 0);
        else begin
          exp_v = exp_q.pop_front();
          chk(out_data == exp_v, "out_data", out_data, exp_v);
        end
      end
      prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
      // model updates from this cycle's handshakes
      if (cfg_valid && cfg_ready) begin
        if (cfg_index < NUM_TAPS) coef_m[cfg_index] = cfg_data;
        else err_m = 1;
      end
      if (in_valid && in_ready) begin
        for (int i = NUM_TAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = in_data;
        y = '0;
        for (int i = 0; i < NUM_TAPS; i++) y = y + coef_m[i] * hist_m[i];
        exp_q.push_back(y);
      end
    end
  end

  task automatic send_cfg(input logic [7:0] idx, input logic [63:0] d);
    int n = 0;
    cfg_valid = 1; cfg_index = idx; cfg_data = d;
    do begin @(negedge clock); n++; end while (!cfg_ready && n < BOUND);
    chk(cfg_ready, "cfg_handshake", cfg_ready, 1);
    @(posedge clock); #1;
    cfg_valid = 0;
  endtask

  task automatic send_in(input logic [63:0] d);
    int n = 0;
    in_valid = 1; in_data = d;
    do begin @(negedge clock); n++; end while (!in_ready && n < BOUND);
    chk(in_ready, "in_handshake", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clock); n++; end while ((busy || out_valid) && n < BOUND);
    chk(!busy, "idle_timeout", busy, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [63:0] s;
    int n;
    reset_n = 0; cfg_valid = 0; in_valid = 0; cfg_index = '0; cfg_data = '0; in_data = '0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk({cfg_ready, in_ready, out_valid, dp_valid, busy, cfg_err} == '0, "reset_flags",
        {cfg_ready, in_ready, out_valid, dp_valid, busy, cfg_err}, 0);
    chk({dp_insn, dp_rs1, dp_rs2, out_data} == '0, "reset_words", dp_rs1 | out_data, 0);
    @(posedge clock); #1; reset_n = 1;
    @(posedge clock); #1;
    chk(cfg_ready && in_ready, "ready_after_reset", {cfg_ready, in_ready}, 2'b11);

    send_cfg(8'd3, 64'h3FE0000000000000);
    chk(dp_valid && dp_insn == OP_LOAD, "load_insn", dp_insn, OP_LOAD);
    chk(dp_rs1 == 64'h3FE0000000000000, "load_rs1", dp_rs1, 64'h3FE0000000000000);
    chk(dp_rs2 == 32'd3, "load_rs2", dp_rs2, 3);
    @(posedge clock); #1;
    chk(!dp_valid, "load_one_cycle", dp_valid, 0);
    send_cfg(8'd7, {$urandom, $urandom});
    chk(cfg_err && !dp_valid && !busy, "bad_index", {cfg_err, dp_valid, busy}, 3'b100);

    send_in({$urandom, $urandom});
    chk(dp_valid && dp_insn == OP_PUSH, "push_insn", dp_insn, OP_PUSH);
    @(posedge clock); #1;
    chk(!dp_valid, "gap_idle", dp_valid, 0);
    @(posedge clock); #1;
    chk(dp_valid && dp_insn == OP_READ, "read_insn", dp_insn, OP_READ);
    wait_idle();

    or_mode = 0;
    send_in({$urandom, $urandom});
    in_valid = 1; in_data = {$urandom, $urandom};
    n = 0;
    do begin @(negedge clock); n++; end while (!out_valid && n < BOUND);
    chk(out_valid, "out_valid_timeout", out_valid, 1);
    repeat (10) begin
      @(negedge clock);
      chk(out_valid && !in_ready && !dp_valid, "backpressure", {out_valid, in_ready, dp_valid}, 3'b100);
    end
    @(posedge clock); #1;
    or_mode = 1;
    send_in(in_data);
    chk(dp_valid && dp_insn == OP_PUSH, "push_after_release", dp_insn, OP_PUSH);
    wait_idle();

    cfg_valid = 1; cfg_index = 8'd1; cfg_data = {$urandom, $urandom};
    in_valid = 1; in_data = {$urandom, $urandom};
    @(negedge clock);
    chk(cfg_ready && !in_ready, "cfg_priority", {cfg_ready, in_ready}, 2'b10);
    @(posedge clock); #1; cfg_valid = 0;
    chk(dp_valid && dp_insn == OP_LOAD, "simul_load", dp_insn, OP_LOAD);
    @(posedge clock); #1;
    @(negedge clock);
    chk(in_ready, "sample_next_idle", in_ready, 1);
    @(posedge clock); #1; in_valid = 0;
    chk(dp_valid && dp_insn == OP_PUSH, "simul_push", dp_insn, OP_PUSH);
    wait_idle();

    send_in({$urandom, $urandom});
    @(posedge clock); #1;
    chk(busy && !dp_valid, "in_gap", {busy, dp_valid}, 2'b10);
    reset_n = 0; #1;
    chk(!busy && !dp_valid && !cfg_ready, "async_reset", {busy, dp_valid, cfg_ready}, 0);
    repeat (2) @(posedge clock); #1; reset_n = 1;
    repeat (10) begin
      @(negedge clock);
      chk(!out_valid, "no_out_after_reset", out_valid, 0);
    end
    @(posedge clock); #1;

    or_mode = 2;
    repeat (80) begin
      if ($urandom_range(0, 9) < 3)
        send_cfg(($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 200)) : 8'($urandom_range(0, 4)),
                 {$urandom, $urandom});
      else begin
        s = {$urandom, $urandom};
        send_in(s);
      end
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    or_mode = 1;
    n = 0;
    do begin @(negedge clock); n++; end while ((exp_q.size() != 0 || busy) && n < BOUND);
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fir_scie_sequencer.md
Name: fir_scie_sequencer

Overview:
Streaming controller in front of the pipelined FIR custom-instruction unit (SCIEPipelined).
- Accepts coefficient-configuration and sample streams over valid/ready handshakes.
- Issues the LOAD / PUSH / READ instruction sequence to the unit with the required spacing.
- Returns one filtered result per accepted sample on an output valid/ready stream.
- Removes instruction-level sequencing from software and from the DMA front-end.

Parameters:
NUM_TAPS, 5, number of coefficient slots; legal cfg_index range is 0..NUM_TAPS-1
DATA_W, 64, width of coefficient, sample and result words
OP_LOAD, 32'h0000000B, dp_insn value for a coefficient load (rs2 = tap index)
OP_PUSH, 32'h0000002B, dp_insn value for a sample push
OP_READ, 32'h0000005B, dp_insn value for a result read
PUSH_GAP, 1, idle cycles between PUSH and READ; range 0..15
READ_LAT, 1, cycles from READ issue to dp_rd being valid; range 1..7

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
cfg_valid  input  1  coefficient write request
cfg_ready  output  1  coefficient accepted this cycle
cfg_index  input  8  tap index
cfg_data  input  DATA_W  coefficient value
in_valid  input  1  sample available
in_ready  output  1  sample accepted this cycle
in_data  input  DATA_W  sample value
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  DATA_W  filtered result
dp_valid  output  1  instruction valid to the FIR unit
dp_insn  output  32  instruction word
dp_rs1  output  DATA_W  operand 1 (coefficient or sample)
dp_rs2  output  32  operand 2 (tap index on LOAD, else 0)
dp_rd  input  DATA_W  result from the FIR unit
busy  output  1  FSM not in IDLE
cfg_err  output  1  sticky; set by an out-of-range cfg_index

Behaviour:
Reset:
- Async assert: FSM = IDLE.
- All outputs 0: cfg_ready, in_ready, out_valid, dp_valid, busy, cfg_err.
- dp_insn, dp_rs1, dp_rs2 and out_data are also 0.
- Reset mid-sequence abandons the operation; no partial output is produced.

FSM states: IDLE, LOAD, PUSH, GAP, READ, WAITRD, HOLD.

IDLE:
- cfg_ready = in_ready = 1, but only one handshake is taken per cycle; cfg has priority.
- While cfg_valid = 1, in_ready is forced to 0.
- A cfg handshake latches index and data, then goes to LOAD.
- cfg_index >= NUM_TAPS: handshake completes, cfg_err is set, FSM stays in IDLE, and no instruction is issued.
- An in handshake latches the sample, then goes to PUSH.

LOAD (1 cycle):
- dp_valid = 1, dp_insn = OP_LOAD, dp_rs1 = coefficient, dp_rs2 = index.
- Then IDLE.

PUSH (1 cycle):
- dp_valid = 1, dp_insn = OP_PUSH, dp_rs1 = sample, dp_rs2 = 0.
- Then GAP, or READ if PUSH_GAP = 0.

GAP:
- dp_valid = 0 for PUSH_GAP cycles, counted down by a 4-bit counter.
- Then READ.

READ (1 cycle):
- dp_valid = 1, dp_insn = OP_READ, dp_rs1 = 0.
- Then WAITRD.

WAITRD:
- Counter runs READ_LAT cycles after the READ edge.
- On the final cycle, dp_rd is registered into out_data; out_valid rises the next cycle (HOLD).

HOLD:
- out_valid = 1; out_data stable until out_ready = 1.
- Handshake: go to IDLE.
- out_valid and out_ready both high on entry: exactly one beat, IDLE the next cycle.

Timing and invariants:
- Minimum sample-to-sample issue period is 4 + PUSH_GAP + READ_LAT cycles: PUSH, gap, READ, wait, HOLD (plus 1 IDLE).
- No new PUSH is issued while a result is unconsumed, so backpressure stalls the FIR unit cleanly.
- When dp_valid = 0, dp_insn, dp_rs1 and dp_rs2 are driven to 0.
- cfg_err clears only on reset.
- busy = (state != IDLE).

Optional Feature:
FIR_SEQ_PERF_EN
- Defined: adds output perf_samples (32 bit), counting completed out handshakes.
- Defined: adds output perf_stall (32 bit), counting cycles in HOLD with out_ready = 0.
- Both counters reset to 0 and wrap at 2^32.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold reset_n = 0 for 5 cycles, release -> all outputs 0; cfg_ready = in_ready = 1 the first cycle after release.
2. Coefficient load: cfg_index = 3, cfg_data = 0x3FE0000000000000 -> the next cycle shows dp_valid = 1, dp_insn = 0x0B, dp_rs1 = 0x3FE0000000000000, dp_rs2 = 3 for exactly 1 cycle; cfg_index = 7 -> cfg_err = 1 and no dp_valid pulse.
3. Sample stream (defaults), stub returning dp_rd = 0x3FE1CD13F6C4A9A0 -> PUSH (0x2B), one idle cycle, READ (0x5B); out_valid asserts 2 cycles after READ with out_data = 0x3FE1CD13F6C4A9A0.
4. Backpressure: hold out_ready = 0 for 10 cycles with in_valid = 1 -> out_data stable, in_ready = 0, no further dp_valid; release -> the next PUSH follows.
5. Simultaneous: cfg_valid = in_valid = 1 in IDLE -> LOAD issued first and the sample is not accepted; the sample is taken in the next IDLE cycle.
6. Reset mid-sequence: assert reset_n in GAP -> busy = 0 and dp_valid = 0 immediately (asynchronous); no out_valid afterwards.
